// File: rtl/array_mem_fill_if.sv
// Access and fill-control bundle for array_mem_fill.
// The master drives requests and fill strobes; the slave (the memory) returns status and read data.
interface array_mem_fill_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
);
  logic          init_req;
  logic [1:0]    init_mode;
  logic [DW-1:0] init_data;
  logic          init_busy;
  logic          init_done;
  logic          req_vld;
  logic          req_rdy;
  logic          req_wen;
  logic [AW-1:0] req_adr;
  logic [DW-1:0] req_wdt;
  logic          rsp_vld;
  logic [DW-1:0] rsp_rdt;
  logic          rsp_err;

  modport master (
    output init_req, init_mode, init_data, req_vld, req_wen, req_adr, req_wdt,
    input  init_busy, init_done, req_rdy, rsp_vld, rsp_rdt, rsp_err
  );

  modport slave (
    input  init_req, init_mode, init_data, req_vld, req_wen, req_adr, req_wdt,
    output init_busy, init_done, req_rdy, rsp_vld, rsp_rdt, rsp_err
  );
endinterface

// File: rtl/array_mem_fill.sv
// Single-port word-addressed RAM with a sequential fill engine (zero, own-index or constant).
// Fill walks ascending (DIR=0) or descending (DIR=1), one word per cycle.
module array_mem_fill #(
  parameter int unsigned DW          = 8,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned AW          = $clog2(DEPTH),
  parameter int unsigned DIR         = 0,
  parameter int unsigned INIT_ON_RST = 1
) (
  input logic               clk,
  input logic               rst,
  array_mem_fill_if.slave   bus
);

  localparam int unsigned XW = (DW > AW) ? DW : AW;
  localparam logic [AW-1:0] FirstIdx = (DIR != 0) ? AW'(DEPTH - 1) : '0;
  localparam logic [AW-1:0] LastIdx  = (DIR != 0) ? '0 : AW'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic [1:0]    mode_q;
  logic [DW-1:0] data_q;
  logic          pend_q;
  logic          rsp_vld_q;
  logic          rsp_err_q;
  logic [DW-1:0] rsp_rdt_q;
  logic [DW-1:0] mem_q [DEPTH];

  logic          start;
  logic          acc;
  logic          in_range;
  logic [XW-1:0] cnt_ext;
  logic [DW-1:0] fill_wd;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;

  always_comb begin
    start    = (state_q == StIdle) && (pend_q || bus.init_req);
    // Pending auto-fill and a same-cycle init_req both take priority over accesses.
    bus.req_rdy = (state_q == StIdle) && !bus.init_req && !pend_q && !rst;
    acc      = bus.req_vld && bus.req_rdy;
    in_range = 32'(bus.req_adr) < DEPTH;
    cnt_ext  = XW'(cnt_q);
    case (mode_q)
      2'd1:    fill_wd = cnt_ext[DW-1:0];
      2'd2:    fill_wd = data_q;
      default: fill_wd = '0;
    endcase
    mem_we = 1'b0;
    mem_wa = bus.req_adr;
    mem_wd = bus.req_wdt;
    if (!rst) begin
      if (state_q == StFill) begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
        mem_wd = fill_wd;
      end else if (acc && bus.req_wen && in_range) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mode_q    <= 2'd0;
      data_q    <= '0;
      pend_q    <= (INIT_ON_RST != 0);
      rsp_vld_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_rdt_q <= '0;
    end else begin
      rsp_vld_q <= acc && !bus.req_wen;
      if (acc && !bus.req_wen) begin
        rsp_err_q <= !in_range;
        rsp_rdt_q <= in_range ? mem_q[bus.req_adr] : '0;
      end
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StFill;
            cnt_q   <= FirstIdx;
            pend_q  <= 1'b0;
            if (pend_q) begin
              mode_q <= 2'd0;
              data_q <= '0;
            end else begin
              mode_q <= bus.init_mode;
              data_q <= bus.init_data;
            end
          end
        end
        StFill: begin
          if (cnt_q == LastIdx) begin
            state_q <= StDone;
          end else if (DIR != 0) begin
            cnt_q <= cnt_q - AW'(1);
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.init_busy = (state_q != StIdle);
  assign bus.init_done = (state_q == StDone);
  assign bus.rsp_vld   = rsp_vld_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdt   = rsp_rdt_q;

endmodule
